joypad_responder: RTL and testbench
===================================

Name: joypad_responder

Overview:
- Controller-side responder for the NES serial joypad protocol; emulates the 4021-style shift register of a standard pad.
- The console core drives joy_strobe/joy_clock; this block returns joy_data from debounced physical buttons.
- Sits between board push-buttons/GPIO and the joystick pins of the NES top, or in a loopback bench against the NES core.

Parameters:
- DEBOUNCE_CYCLES, 21477, clock cycles between button sample ticks (~1 ms at 21.477 MHz); legal range 2..2^20.
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer; legal range 2..4.
- TURBO_DIV, 2, strobe frames per turbo toggle; used only with TURBO_EN.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- buttons  in  8  raw buttons, active-high; [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right.
- joy_strobe  in  1  latch from console, active-high, asynchronous to clock.
- joy_clock  in  1  shift clock from console, asynchronous to clock.
- joy_data  out  1  serial data, active-low (0 = pressed).
- buttons_db  out  8  debounced button state, active-high.
- bit_count  out  4  shifts since last latch, saturates at 8.
- latch_pulse  out  1  one-cycle pulse when the synchronized strobe falls.
- turbo  in  2  [0]=turbo A, [1]=turbo B; present only when TURBO_EN is defined.

Behaviour:
- Reset values: joy_data=1, buttons_db=0, bit_count=0, latch_pulse=0, shift register=8'hFF, all synchronizer flops=0, debounce counter=0.
- Synchronizers: buttons, joy_strobe and joy_clock each pass through SYNC_STAGES flops. Edge detection uses the last synchronizer stage against one more registered copy.
- Debounce:
  - A shared counter counts 0..DEBOUNCE_CYCLES-1 and emits a tick on wrap.
  - On each tick the synchronized buttons are captured into sample register S.
  - Per bit: buttons_db[i] takes the value S[i] only when two consecutive tick samples agree and differ from the current buttons_db[i].
  - A change is therefore reflected after 2 to 3 ticks.
- Shift register sr[7:0], active-low, holds ~eff, where eff is buttons_db (or the turbo-modified value). sr[0] drives joy_data combinationally from the register.
- Strobe high (synchronized):
  - sr <= ~eff every cycle; bit_count <= 0.
  - joy_clock edges are ignored (reload wins).
  - joy_data tracks A live.
- Strobe falling edge:
  - latch_pulse=1 for that cycle.
  - The final value loaded while strobe was high is kept.
- Clock rising edge with strobe low:
  - sr <= {1'b0, sr[7:1]}, i.e. fill with 0 (pressed level), so reads after the 8th return "pressed", as on a real pad.
  - bit_count <= min(bit_count+1, 8).
- Clock falling edge: no action. The console samples on its falling edge.
- Latency: joy_data changes SYNC_STAGES+1 clock cycles after the raw joy_clock rise. The console's clock-high time must exceed SYNC_STAGES+2 cycles.
- Simultaneous events in the same cycle:
  - Strobe rise and clock rise: load wins.
  - Strobe fall and clock rise: the shift applies to the already-latched value.
- Reset asserted mid-frame: all state returns to reset values immediately. After release, joy_data stays 1 until the next strobe.
- More than 8 clock rises: sr is all 0 and bit_count holds at 8.

Optional Feature:
- Macro: JOYPAD_TURBO_EN.
- Defined:
  - turbo port exists.
  - A frame counter increments on each latch_pulse; a phase bit toggles when the counter reaches TURBO_DIV-1, then the counter clears.
  - eff[0] = buttons_db[0] & (~turbo[0] | phase); likewise eff[1] with turbo[1].
  - phase resets to 1.
- Undefined: turbo port, frame counter and phase logic are absent; eff = buttons_db.

Test Plan:
- Reset, then hold buttons=8'h00 for 10 ticks -> buttons_db=0. Strobe, then 8 clocks -> joy_data reads 1 on all 8 bits; a 9th read returns 0; bit_count=8.
- Hold buttons=8'b1000_1001 (A, Start, Right) stable 3 ticks, strobe pulse, 8 clock pulses -> console sees inverted bits 1,0,0,1,0,0,0,1 in order A..Right; latch_pulse pulses once.
- buttons[0] glitches high for DEBOUNCE_CYCLES/2 cycles -> buttons_db[0] stays 0. Held for 3 ticks -> buttons_db[0]=1.
- Strobe held high while 5 clock pulses arrive -> no shift, bit_count=0, joy_data follows A.
- Assert reset_n=0 after 3 shifts -> joy_data=1 and bit_count=0 immediately. Next strobe and read -> full fresh 8-bit frame.
- JOYPAD_TURBO_EN, TURBO_DIV=2, turbo=2'b01, A held, 8 frames -> A read pressed on frames 1,2,5,6 and released on frames 3,4,7,8.

Source files
------------

// File: rtl/joypad_responder.sv
// rtl/joypad_responder.sv - NES serial joypad responder (4021-style shift register); optional turbo via JOYPAD_TURBO_EN
module joypad_responder #(
    parameter int DEBOUNCE_CYCLES = 21477,
    parameter int SYNC_STAGES     = 2,
    parameter int TURBO_DIV       = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] buttons,
    input  logic       joy_strobe,
    input  logic       joy_clock,
`ifdef JOYPAD_TURBO_EN
    input  logic [1:0] turbo,
`endif
    output logic       joy_data,
    output logic [7:0] buttons_db,
    output logic [3:0] bit_count,
    output logic       latch_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [7:0]             btn_sync_q [SYNC_STAGES];
    logic [7:0]             btn_sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] strb_sync_q, strb_sync_d;
    logic [SYNC_STAGES-1:0] jclk_sync_q, jclk_sync_d;
    logic                   strb_prev_q, strb_prev_d;
    logic                   jclk_prev_q, jclk_prev_d;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             samp_q, samp_d;
    logic [7:0]             samp_prev_q, samp_prev_d;
    logic [7:0]             db_q, db_d;

    logic [7:0]             sr_q, sr_d;
    logic [3:0]             bc_q, bc_d;

    logic                   strb_s;
    logic                   jclk_s;
    logic                   jclk_rise;
    logic                   strb_fall;
    logic                   tick;
    logic [7:0]             agree;
    logic [7:0]             eff;

    assign strb_s    = strb_sync_q[SYNC_STAGES-1];
    assign jclk_s    = jclk_sync_q[SYNC_STAGES-1];
    assign jclk_rise = jclk_s & ~jclk_prev_q;
    assign strb_fall = ~strb_s & strb_prev_q;
    assign tick      = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign agree     = ~(samp_q ^ samp_prev_q);

    always_comb begin
        btn_sync_d[0] = buttons;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            btn_sync_d[i] = btn_sync_q[i-1];
        end
        strb_sync_d = {strb_sync_q[SYNC_STAGES-2:0], joy_strobe};
        jclk_sync_d = {jclk_sync_q[SYNC_STAGES-2:0], joy_clock};
        strb_prev_d = strb_s;
        jclk_prev_d = jclk_s;
    end

    // Two sample registers give the "two consecutive ticks agree" window.
    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        samp_d      = samp_q;
        samp_prev_d = samp_prev_q;
        db_d        = db_q;
        if (tick) begin
            cnt_d       = '0;
            samp_d      = btn_sync_q[SYNC_STAGES-1];
            samp_prev_d = samp_q;
            db_d        = (db_q & ~agree) | (samp_q & agree);
        end
    end

`ifdef JOYPAD_TURBO_EN
    localparam int TD_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [TD_W-1:0] frame_q, frame_d;
    logic            phase_q, phase_d;

    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (strb_fall) begin
            if (frame_q == TD_W'(TURBO_DIV - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + TD_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_q <= '0;
            phase_q <= 1'b1;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        eff    = db_q;
        eff[0] = db_q[0] & (~turbo[0] | phase_q);
        eff[1] = db_q[1] & (~turbo[1] | phase_q);
    end
`else
    always_comb begin
        eff = db_q;
    end
`endif

    // Reload has priority over shifting; zeros fill in so reads past 8 look pressed.
    always_comb begin
        sr_d = sr_q;
        bc_d = bc_q;
        if (strb_s) begin
            sr_d = ~eff;
            bc_d = 4'd0;
        end else if (jclk_rise) begin
            sr_d = {1'b0, sr_q[7:1]};
            if (bc_q != 4'd8) begin
                bc_d = bc_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                btn_sync_q[i] <= '0;
            end
            strb_sync_q <= '0;
            jclk_sync_q <= '0;
            strb_prev_q <= 1'b0;
            jclk_prev_q <= 1'b0;
            cnt_q       <= '0;
            samp_q      <= '0;
            samp_prev_q <= '0;
            db_q        <= '0;
            sr_q        <= 8'hFF;
            bc_q        <= 4'd0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                btn_sync_q[i] <= btn_sync_d[i];
            end
            strb_sync_q <= strb_sync_d;
            jclk_sync_q <= jclk_sync_d;
            strb_prev_q <= strb_prev_d;
            jclk_prev_q <= jclk_prev_d;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            samp_prev_q <= samp_prev_d;
            db_q        <= db_d;
            sr_q        <= sr_d;
            bc_q        <= bc_d;
        end
    end

    assign joy_data    = sr_q[0];
    assign buttons_db  = db_q;
    assign bit_count   = bc_q;
    assign latch_pulse = strb_fall;

endmodule

// File: tb/tb_joypad_responder.sv
// tb/tb_joypad_responder.sv - scoreboard bench for joypad_responder
module tb_joypad_responder;

    localparam int DEB = 16;
    localparam int SYN = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic       joy_strobe = 1'b0;
    logic       joy_clock = 1'b0;
    logic [1:0] turbo = 2'b00;
    logic       joy_data;
    logic [7:0] buttons_db;
    logic [3:0] bit_count;
    logic       latch_pulse;

    int         checks = 0;
    int         failures = 0;
    int         lp_cnt = 0;
    logic       sb_q [$];

    joypad_responder #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYN),
        .TURBO_DIV      (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .buttons    (buttons),
        .joy_strobe (joy_strobe),
        .joy_clock  (joy_clock),
`ifdef JOYPAD_TURBO_EN
        .turbo      (turbo),
`endif
        .joy_data   (joy_data),
        .buttons_db (buttons_db),
        .bit_count  (bit_count),
        .latch_pulse(latch_pulse)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (latch_pulse) lp_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_buttons(input logic [7:0] v);
        @(negedge clock);
        buttons = v;
        wait_cycles(4 * DEB);
    endtask

    task automatic push_frame(input logic [7:0] eff);
        sb_q.delete();
        for (int i = 0; i < 8; i++) sb_q.push_back(~eff[i]);
        sb_q.push_back(1'b0);
    endtask

    task automatic pulse_strobe;
        @(negedge clock);
        joy_strobe = 1'b1;
        wait_cycles(6);
        joy_strobe = 1'b0;
        wait_cycles(6);
    endtask

    task automatic pulse_clock;
        @(negedge clock);
        joy_clock = 1'b1;
        wait_cycles(6);
        joy_clock = 1'b0;
        wait_cycles(6);
    endtask

    task automatic read_bit(input string tag);
        logic e;
        @(negedge clock);
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val(tag, {31'd0, joy_data}, {31'd0, e});
        end
    endtask

    task automatic run_frame(input int n_reads);
        pulse_strobe();
        for (int i = 0; i < n_reads; i++) begin
            if (i > 0) pulse_clock();
            read_bit("joy_data");
        end
    endtask

    initial begin
        logic [7:0] pat;
        int         lp0;

        wait_cycles(3);
        check_val("rst_joy_data", {31'd0, joy_data}, 32'd1);
        check_val("rst_db", {24'd0, buttons_db}, 32'd0);
        check_val("rst_bit_count", {28'd0, bit_count}, 32'd0);
        check_val("rst_latch", {31'd0, latch_pulse}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // all released: 8 reads of 1 then a 0
        wait_cycles(10 * DEB);
        check_val("db_idle", {24'd0, buttons_db}, 32'd0);
        push_frame(8'h00);
        run_frame(8);
        pulse_clock();
        read_bit("ninth_read");
        check_val("bc_sat", {28'd0, bit_count}, 32'd8);
        pulse_clock();
        check_val("bc_hold", {28'd0, bit_count}, 32'd8);

        // A, Start, Right
        set_buttons(8'h89);
        check_val("db_89", {24'd0, buttons_db}, 32'h89);
        lp0 = lp_cnt;
        push_frame(8'h89);
        run_frame(9);
        check_val("latch_once", lp_cnt - lp0, 32'd1);

        // glitch on A must be filtered, a held press must pass
        set_buttons(8'h00);
        @(negedge clock);
        buttons = 8'h01;
        wait_cycles(DEB / 2);
        buttons = 8'h00;
        wait_cycles(4 * DEB);
        check_val("glitch_db", {24'd0, buttons_db}, 32'h00);
        set_buttons(8'h01);
        check_val("held_db", {24'd0, buttons_db}, 32'h01);

        // strobe held: clocks ignored, joy_data follows A live
        @(negedge clock);
        joy_strobe = 1'b1;
        wait_cycles(6);
        for (int i = 0; i < 5; i++) pulse_clock();
        check_val("strb_bc", {28'd0, bit_count}, 32'd0);
        check_val("strb_a_pressed", {31'd0, joy_data}, 32'd0);
        set_buttons(8'h00);
        check_val("strb_a_released", {31'd0, joy_data}, 32'd1);
        joy_strobe = 1'b0;
        wait_cycles(6);

        // reset mid-frame, then a fresh full frame
        set_buttons(8'h5A);
        push_frame(8'h5A);
        run_frame(3);
        pulse_clock();
        check_val("mid_bc", {28'd0, bit_count}, 32'd3);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_data", {31'd0, joy_data}, 32'd1);
        check_val("mid_rst_bc", {28'd0, bit_count}, 32'd0);
        check_val("mid_rst_db", {24'd0, buttons_db}, 32'd0);
        sb_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        wait_cycles(4 * DEB);
        check_val("post_rst_data", {31'd0, joy_data}, 32'd1);
        check_val("post_rst_db", {24'd0, buttons_db}, 32'h5A);
        push_frame(8'h5A);
        run_frame(9);

        for (int k = 0; k < 3; k++) begin
            pat = 8'($urandom_range(0, 255));
            set_buttons(pat);
            check_val("rand_db", {24'd0, buttons_db}, {24'd0, pat});
            push_frame(pat);
            run_frame(9);
            check_val("rand_bc", {28'd0, bit_count}, 32'd8);
        end

`ifdef JOYPAD_TURBO_EN
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        turbo = 2'b01;
        set_buttons(8'h01);
        for (int f = 1; f <= 8; f++) begin
            sb_q.delete();
            sb_q.push_back((f == 3 || f == 4 || f == 7 || f == 8) ? 1'b1 : 1'b0);
            run_frame(1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
